// File: rtl/clk_div_delay_tap_ctrl_if.sv
// Tap-command handshake between the alignment logic and the
// delay-line tap sequencer.
interface clk_div_delay_tap_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_count,
    input  cmd_ready,
    input  done,
    input  err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_count,
    output cmd_ready,
    output done,
    output err
  );
endinterface

// File: rtl/clk_div_delay_tap_ctrl.sv
// Sequencer driving DIR/MOVE/LOAD of the ICB_CLKDIVDELAY delay line,
// spacing pulses by a settle gap and shadowing the tap position.
module clk_div_delay_tap_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int TAP_MAX       = 127,
  parameter int LOAD_VAL      = 1
) (
  input  logic                     sclk,
  input  logic                     reset,
  clk_div_delay_tap_ctrl_if.slave  cmd,
  output logic [7:0]               tap_pos,
  output logic                     delay_line_dir,
  output logic                     delay_line_move,
  output logic                     delay_line_load,
  input  logic                     delay_line_out_of_range
);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, GAP, LOADP, FIN
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [7:0] G_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] T_MAX   = 8'(TAP_MAX);
  localparam logic [7:0] L_VAL   = 8'(LOAD_VAL);

  state_t     state, nxt;
  logic [1:0] op_q;
  logic [7:0] rem_q;
  logic [7:0] gcnt_q;
  logic       oor_q;

  logic       accept;
  logic       is_inc;
  logic       gap_end;
  logic       abort;
  logic [7:0] chk_tap;
  logic [7:0] chk_rem;
  logic       at_lim;
  logic       err_set;

  logic       ready_d, done_d, err_d;
  logic       move_d, load_d, dir_d;
  logic [7:0] tap_d;

  assign accept  = cmd.cmd_valid & cmd.cmd_ready;
  assign is_inc  = (op_q == OP_INC);
  assign gap_end = (state == GAP) && (gcnt_q == 8'd0);
  assign abort   = oor_q | delay_line_out_of_range;

  // The step check sees the tap/remaining as they will be after this step.
  always_comb begin
    chk_tap = tap_pos;
    chk_rem = rem_q;
    if (state == GAP) begin
      chk_tap = is_inc ? tap_pos + 8'd1 : tap_pos - 8'd1;
      chk_rem = rem_q - 8'd1;
    end
    at_lim = is_inc ? (chk_tap == T_MAX) : (chk_tap == 8'd0);
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_LOAD:        nxt = LOADP;
            OP_INC, OP_DEC: nxt = SETUP;
            default: begin
              nxt     = FIN;
              err_set = 1'b1;
            end
          endcase
        end
      end
      SETUP, GAP: begin
        if (state == SETUP || gcnt_q == 8'd0) begin
          if (state == GAP && op_q == OP_LOAD) begin
            nxt = FIN;
          end else if (state == GAP && abort) begin
            nxt     = FIN;
            err_set = 1'b1;
          end else if (chk_rem == 8'd0) begin
            nxt = FIN;
          end else if (at_lim) begin
            nxt     = FIN;
            err_set = 1'b1;
          end else begin
            nxt = PULSE;
          end
        end
      end
      PULSE:   nxt = GAP;
      LOADP:   nxt = GAP;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state == IDLE) && !accept;
    done_d  = (state == FIN);
    move_d  = (state == PULSE);
    load_d  = (state == LOADP);
    dir_d   = (state == SETUP) ? is_inc : delay_line_dir;
    err_d   = err_set | (cmd.err & ~accept);
    tap_d   = tap_pos;
    if (gap_end) begin
      if (op_q == OP_LOAD) tap_d = L_VAL;
      else if (!abort)     tap_d = chk_tap;
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      cmd.cmd_ready   <= 1'b0;
      cmd.done        <= 1'b0;
      cmd.err         <= 1'b0;
      delay_line_dir  <= 1'b0;
      delay_line_move <= 1'b0;
      delay_line_load <= 1'b0;
      tap_pos         <= L_VAL;
      op_q            <= OP_LOAD;
      rem_q           <= 8'd0;
      gcnt_q          <= 8'd0;
      oor_q           <= 1'b0;
    end else begin
      cmd.cmd_ready   <= ready_d;
      cmd.done        <= done_d;
      cmd.err         <= err_d;
      delay_line_dir  <= dir_d;
      delay_line_move <= move_d;
      delay_line_load <= load_d;
      tap_pos         <= tap_d;
      if (accept) begin
        op_q  <= cmd.cmd_op;
        rem_q <= cmd.cmd_count;
      end else if (gap_end && !abort) begin
        rem_q <= chk_rem;
      end
      if (state == PULSE || state == LOADP)
        gcnt_q <= G_LAST;
      else if (state == GAP && gcnt_q != 8'd0)
        gcnt_q <= gcnt_q - 8'd1;
      if (state == PULSE)
        oor_q <= delay_line_out_of_range;
      else if (state == GAP)
        oor_q <= oor_q | delay_line_out_of_range;
    end
  end

endmodule

// File: doc/clk_div_delay_tap_ctrl.md
# clk_div_delay_tap_ctrl

Sequencer that drives the delay-line control port of the PolarFire clock-divider/delay cell (ICB_CLKDIVDELAY) used in the IOD receive clock path. It accepts tap commands (load, increment by N, decrement by N) from the BCLK/SCLK alignment logic. It issues correctly spaced DELAY_LINE_DIR/MOVE/LOAD pulses, honours DELAY_LINE_OUT_OF_RANGE, and keeps a shadow of the current tap position.

## Interface
Parameters:
- SETTLE_CYCLES, 4: idle cycles after each MOVE/LOAD pulse before the next action; legal range 1..255.
- TAP_MAX, 127: highest legal tap; increments never move past it.
- LOAD_VAL, 1: tap value the delay cell takes on LOAD; matches the cell's DELAY_LINE_VAL.

Ports:
- SCLK  in  1  single clock; all logic is on the rising edge; DELAY_LINE_OUT_OF_RANGE is synchronous to SCLK.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  high only in IDLE; a command is accepted on an edge where CMD_VALID & CMD_READY.
- CMD_OP  in  2  00 = load, 01 = increment, 10 = decrement, 11 = reserved.
- CMD_COUNT  in  8  number of steps for increment/decrement; ignored for load.
- DONE  out  1  one-cycle pulse when a command completes.
- ERR  out  1  sticky; set on abort or reserved op; cleared when the next command is accepted.
- TAP_POS  out  8  shadow tap position.
- DELAY_LINE_DIR  out  1  1 = increment, 0 = decrement; to cell.
- DELAY_LINE_MOVE  out  1  one-cycle step pulse; to cell.
- DELAY_LINE_LOAD  out  1  one-cycle load pulse; to cell.
- DELAY_LINE_OUT_OF_RANGE  in  1  from cell.

## Operation
- All outputs are registered.
- States: IDLE, SETUP, PULSE, GAP, LOADP, FIN.
- Command capture: CMD_OP and CMD_COUNT are latched at accept. ERR is cleared at accept.
- IDLE → LOADP on op 00.
- IDLE → SETUP on op 01/10. DIR is driven in SETUP and held through the whole command; it retains its value in IDLE.
- IDLE → FIN on op 11, with ERR set.
- LOADP:
  - DELAY_LINE_LOAD = 1 for this cycle.
  - Then → GAP for SETTLE_CYCLES cycles.
  - Then → FIN, with TAP_POS = LOAD_VAL.
  - OUT_OF_RANGE is ignored for load.
- Step check: performed in SETUP and at the end of every GAP of a step command.
  - Remaining == 0 → FIN, no error.
  - Limit reached (increment with TAP_POS == TAP_MAX, or decrement with TAP_POS == 0) → FIN, ERR set, no pulse.
  - Otherwise → PULSE.
- PULSE: DELAY_LINE_MOVE = 1 for this cycle, then → GAP.
- GAP: lasts SETTLE_CYCLES cycles. Leaving GAP:
  - If OUT_OF_RANGE was not sampled high in the PULSE cycle or any GAP cycle of this step: TAP_POS ±1, remaining −1, then step check.
  - Otherwise: TAP_POS unchanged, ERR set, remaining steps cancelled → FIN.
- FIN: DONE = 1 for one cycle → IDLE.
- Only one pulse type is ever active at a time; MOVE and LOAD are never high together.
- While busy, CMD_VALID is ignored; nothing is queued.
- TAP_POS arithmetic is 8-bit and never wraps, because the limit check precedes every pulse.

## Timing
- Reset values (asserted asynchronously): CMD_READY 0, DONE 0, ERR 0, DIR 0, MOVE 0, LOAD 0, TAP_POS = LOAD_VAL, state IDLE. CMD_READY rises on the first SCLK edge after RESET deasserts.
- Latency, G = SETTLE_CYCLES, accept edge = cycle 0:
  - Step command with N steps and no abort: pulse k (1..N) in cycle 2 + (k−1)(G+1); DONE in cycle 2 + N(G+1).
  - Step command with N = 0: DONE in cycle 2.
  - Load: LOAD in cycle 1; DONE in cycle 2 + G.
  - Reserved op: DONE in cycle 1.
- CMD_READY is low from the cycle after accept through the DONE cycle, and high again the cycle after DONE.
- RESET mid-command: pulses stop immediately; no DONE is issued; the command is lost.

## Test plan
- Reset with G = 4, then INC, COUNT = 3 → MOVE high in cycles 2, 7, 12; DIR = 1 from cycle 1; DONE in cycle 17; TAP_POS = 4; ERR = 0.
- From TAP_POS = 4, DEC, COUNT = 2 → DIR = 0; MOVE high in cycles 2 and 7; DONE in cycle 12; TAP_POS = 2.
- From TAP_POS = 1, DEC, COUNT = 3 → single MOVE in cycle 2; DONE in cycle 7; TAP_POS = 0; ERR = 1. The next LOAD clears ERR, gives LOAD in cycle 1, DONE in cycle 6, TAP_POS = 1.
- INC, COUNT = 5, with OUT_OF_RANGE forced high in cycle 4 → one MOVE only; DONE in cycle 7; TAP_POS unchanged; ERR = 1.
- Assert RESET during the GAP of an INC → MOVE/LOAD/DIR/DONE = 0 immediately; TAP_POS = 1; CMD_READY = 1 one edge after release. Also: op 11 → DONE in cycle 1 with ERR = 1 and no MOVE/LOAD activity. Also: CMD_VALID held high while busy → no second accept.
